dcache_sram_sched: RTL

- Scheduler that shares one single-ported dcache SRAM bank (data/tag/valid-dirty behind one address) among NR_PORTS requesters.
- Port 0 is the miss handler and has fixed top priority. Ports 1..NR_PORTS-1 are the PTW, load and store controllers, served round-robin.
- Provides lock ownership for multi-cycle atomic sequences.
- Contains the invalidation sweep engine that clears every SRAM word after reset and on demand.

---
 rtl/dcache_sram_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dcache_sram_sched.sv
// Shared dcache SRAM bank scheduler: fixed-priority miss port, round-robin
// for the rest, lock ownership for atomics, and the invalidation sweep.
module dcache_sram_sched #(
  parameter int NR_PORTS   = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_PORTS-1:0]              req_i,
  input  logic [NR_PORTS-1:0]              lock_i,
  input  logic [NR_PORTS-1:0]              we_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
  output logic [NR_PORTS-1:0]              gnt_o,
  output logic [NR_PORTS-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  input  logic                             init_req_i,
  output logic                             init_busy_o,
  output logic                             init_done_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int PW   = (NR_PORTS > 2) ? $clog2(NR_PORTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [PW-1:0] TOP = PW'(NR_PORTS - 1);

  typedef enum logic [1:0] {INIT, ARB, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic                  owner_vld_q, owner_vld_d;
  logic                  pend_q, pend_d;
  logic [NR_PORTS-1:0]   rvalid_q;

  logic [PW-1:0]         rr_pick;
  logic                  rr_hit;
  logic [PW:0]           cand;
  logic [PW-1:0]         sel;
  logic                  sel_vld;
  logic                  done;

  // First requester at or above the rr pointer, wrapping past the top to 1
  always_comb begin
    rr_pick = '0;
    rr_hit  = 1'b0;
    cand    = '0;
    for (int i = 0; i < NR_PORTS - 1; i++) begin
      cand = {1'b0, rr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NR_PORTS))
        cand = cand - (PW+1)'(NR_PORTS - 1);
      if (!rr_hit && req_i[cand[PW-1:0]]) begin
        rr_hit  = 1'b1;
        rr_pick = cand[PW-1:0];
      end
    end
  end

  // Next state, grant selection, lock ownership and sweep index
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    pend_d      = pend_q;
    sel         = '0;
    sel_vld     = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      INIT: begin
        if (idx_q == LAST) begin
          done    = 1'b1;
          idx_d   = '0;
          state_d = ARB;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      ARB: begin
        if (pend_q || init_req_i) begin
          pend_d  = 1'b0;
          state_d = INIT;
        end else if (req_i[0]) begin
          sel_vld = 1'b1;
          sel     = '0;
        end else if (rr_hit) begin
          sel_vld = 1'b1;
          sel     = rr_pick;
          rr_d    = (rr_pick == TOP) ? PW'(1) : rr_pick + PW'(1);
        end
        if (sel_vld && lock_i[sel]) begin
          owner_d     = sel;
          owner_vld_d = 1'b1;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (owner_vld_q && req_i[owner_q]) begin
          sel_vld = 1'b1;
          sel     = owner_q;
        end
        if (init_req_i)
          pend_d = 1'b1;
        if (!lock_i[owner_q]) begin
          owner_vld_d = 1'b0;
          state_d     = ARB;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // SRAM port mux: sweep writes zeros, otherwise the granted port passes through
  always_comb begin
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (state_q == INIT) begin
      mem_req_o  = ~rst_i;
      mem_we_o   = 1'b1;
      mem_addr_o = idx_q;
      mem_be_o   = '1;
    end else if (sel_vld) begin
      gnt_o[sel]  = 1'b1;
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[sel];
      mem_addr_o  = ADDR_WIDTH'(addr_i >> (sel * ADDR_WIDTH));
      mem_wdata_o = DATA_WIDTH'(wdata_i >> (sel * DATA_WIDTH));
      mem_be_o    = BE_W'(be_i >> (sel * BE_W));
    end
  end

  assign init_done_o = done;
  assign init_busy_o = (state_q == INIT);
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = mem_rdata_i;

  // State registers; reads are tagged for return one cycle after grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      idx_q       <= '0;
      rr_q        <= PW'(1);
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      pend_q      <= 1'b0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      pend_q      <= pend_d;
      rvalid_q    <= gnt_o & ~we_i;
    end
  end

endmodule
